issue_select: RTL and testbench

ISSUE_SELECT -- requirements
Module: issue_select

---
 rtl/issue_select.sv | 131 +++++++++++++
 tb/tb_issue_select.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_select.sv
// Out-of-order issue select: per-FU oldest-first arbitration over a scheduler window
// tracked by an allocation-order age matrix; grants and frees are registered.
module issue_select #(
    parameter int unsigned NUM_ROWS = 8,
    parameter int unsigned NUM_FUS  = 4,
    localparam int unsigned RW = $clog2(NUM_ROWS),
    localparam int unsigned FW = $clog2(NUM_FUS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [RW-1:0]         alloc_row,
    input  logic [FW-1:0]         alloc_fu,
    input  logic [NUM_ROWS-1:0]   request_vector,
    input  logic [NUM_FUS-1:0]    fu_ready,
    input  logic                  flush,
    output logic [NUM_FUS-1:0]    grant_valid,
    output logic [NUM_FUS*RW-1:0] grant_row,
    output logic [NUM_ROWS-1:0]   free_mask,
    output logic [RW:0]           valid_count,
    output logic                  alloc_err
);

    logic [NUM_ROWS-1:0]   valid_q, valid_d;
    logic [FW-1:0]         fu_type_q [NUM_ROWS];
    logic [FW-1:0]         fu_type_d [NUM_ROWS];
    // older_q[i][j] = 1 when row i was allocated before row j
    logic [NUM_ROWS-1:0]   older_q [NUM_ROWS];
    logic [NUM_ROWS-1:0]   older_d [NUM_ROWS];

    logic [NUM_FUS-1:0]    grant_valid_q;
    logic [NUM_FUS*RW-1:0] grant_row_q;
    logic [NUM_ROWS-1:0]   free_mask_q;
    logic [RW:0]           valid_count_q, count_d;
    logic                  alloc_err_q;

    logic [NUM_FUS-1:0]    fire;
    logic [NUM_FUS*RW-1:0] row_sel;
    logic [NUM_ROWS-1:0]   granted;
    logic                  alloc_ok;

    always_comb begin : arbitrate
        logic [NUM_ROWS-1:0] cand;
        logic [NUM_ROWS-1:0] win;
        granted = '0;
        fire    = '0;
        row_sel = '0;
        cand    = '0;
        win     = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                cand[i] = valid_q[i] & request_vector[i] & (fu_type_q[i] == FW'(f));
            end
            // A candidate wins when no other candidate is older; valid rows are totally ordered.
            for (int i = 0; i < NUM_ROWS; i++) begin
                win[i] = cand[i];
                for (int j = 0; j < NUM_ROWS; j++) begin
                    if (cand[j] && older_q[j][i]) begin
                        win[i] = 1'b0;
                    end
                end
            end
            if ((|win) && fu_ready[f]) begin
                fire[f] = 1'b1;
                granted = granted | win;
                for (int i = 0; i < NUM_ROWS; i++) begin
                    if (win[i]) begin
                        row_sel[f*RW +: RW] = RW'(i);
                    end
                end
            end
        end
    end

    always_comb begin : next_state
        valid_d   = valid_q & ~granted;
        fu_type_d = fu_type_q;
        older_d   = older_q;
        // Validity is checked before this edge's grants, so a row being granted now still errors.
        alloc_ok  = alloc_valid && !valid_q[alloc_row];
        if (alloc_ok) begin
            valid_d[alloc_row]   = 1'b1;
            fu_type_d[alloc_row] = alloc_fu;
            older_d[alloc_row]   = '0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                older_d[i][alloc_row] = valid_q[i];
            end
        end
        count_d = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            count_d = count_d + (RW+1)'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            fu_type_q     <= '{default: '0};
            older_q       <= '{default: '0};
            grant_valid_q <= '0;
            grant_row_q   <= '0;
            free_mask_q   <= '0;
            valid_count_q <= '0;
            alloc_err_q   <= 1'b0;
        end else if (flush) begin
            valid_q       <= '0;
            older_q       <= '{default: '0};
            grant_valid_q <= '0;
            grant_row_q   <= '0;
            free_mask_q   <= '0;
            valid_count_q <= '0;
            alloc_err_q   <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            fu_type_q     <= fu_type_d;
            older_q       <= older_d;
            grant_valid_q <= fire;
            grant_row_q   <= row_sel;
            free_mask_q   <= granted;
            valid_count_q <= count_d;
            alloc_err_q   <= alloc_valid && !alloc_ok;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_row   = grant_row_q;
    assign free_mask   = free_mask_q;
    assign valid_count = valid_count_q;
    assign alloc_err   = alloc_err_q;

endmodule

// File: tb/tb_issue_select.sv
// Self-checking bench for issue_select: directed vector table, hand-written corner
// sequences, then random stimulus against an age-ordered list model.
module tb_issue_select;

    localparam int NR = 8;
    localparam int NF = 4;
    localparam int RW = 3;
    localparam int FW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            alloc_valid;
    logic [RW-1:0]   alloc_row;
    logic [FW-1:0]   alloc_fu;
    logic [NR-1:0]   request_vector;
    logic [NF-1:0]   fu_ready;
    logic            flush;
    logic [NF-1:0]   grant_valid;
    logic [NF*RW-1:0] grant_row;
    logic [NR-1:0]   free_mask;
    logic [RW:0]     valid_count;
    logic            alloc_err;

    always #5 clk = ~clk;

    issue_select #(.NUM_ROWS(NR), .NUM_FUS(NF)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_row      (alloc_row),
        .alloc_fu       (alloc_fu),
        .request_vector (request_vector),
        .fu_ready       (fu_ready),
        .flush          (flush),
        .grant_valid    (grant_valid),
        .grant_row      (grant_row),
        .free_mask      (free_mask),
        .valid_count    (valid_count),
        .alloc_err      (alloc_err)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic             r, fl, av;
        logic [RW-1:0]    ar;
        logic [FW-1:0]    af;
        logic [NR-1:0]    req;
        logic [NF-1:0]    rdy;
        logic [NF-1:0]    gv;
        logic [NF*RW-1:0] gr;
        logic [NR-1:0]    fr;
        logic [RW:0]      cnt;
        logic             err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit fl, input bit av, input int ar, input int af,
                       input int req, input int rdy, input int gv, input int gr, input int fr,
                       input int cnt, input bit err);
        vec_t v;
        v.r = r; v.fl = fl; v.av = av; v.ar = 3'(ar); v.af = 2'(af);
        v.req = 8'(req); v.rdy = 4'(rdy); v.gv = 4'(gv); v.gr = 12'(gr);
        v.fr = 8'(fr); v.cnt = 4'(cnt); v.err = err;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [NF-1:0] gv,
                             input logic [NF*RW-1:0] gr, input logic [NR-1:0] fr,
                             input logic [RW:0] cnt, input logic err);
        check({tag, "/grant_valid"}, 32'(grant_valid), 32'(gv));
        check({tag, "/grant_row"}, 32'(grant_row), 32'(gr));
        check({tag, "/free_mask"}, 32'(free_mask), 32'(fr));
        check({tag, "/valid_count"}, 32'(valid_count), 32'(cnt));
        check({tag, "/alloc_err"}, 32'(alloc_err), 32'(err));
    endtask

    task automatic drive(input bit r, input bit fl, input bit av, input logic [RW-1:0] ar,
                         input logic [FW-1:0] af, input logic [NR-1:0] req,
                         input logic [NF-1:0] rdy);
        rst = r; flush = fl; alloc_valid = av; alloc_row = ar; alloc_fu = af;
        request_vector = req; fu_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: rows kept in a list in allocation order; oldest = front.
    int order[$];
    int mfu[NR];
    logic [NF-1:0]    e_gv;
    logic [NF*RW-1:0] e_gr;
    logic [NR-1:0]    e_fr;
    logic [RW:0]      e_cnt;
    logic             e_err;

    task automatic model_edge();
        int keep[$];
        bit inlist;
        bit done;
        int r;
        e_gv = '0; e_gr = '0; e_fr = '0; e_err = 1'b0;
        if (rst) begin
            order.delete();
            foreach (mfu[i]) mfu[i] = 0;
            e_cnt = '0;
        end else if (flush) begin
            order.delete();
            e_cnt = '0;
        end else begin
            for (int f = 0; f < NF; f++) begin
                done = 1'b0;
                for (int k = 0; k < order.size(); k++) begin
                    r = order[k];
                    if (!done && request_vector[r] && mfu[r] == f) begin
                        done = 1'b1;
                        if (fu_ready[f]) begin
                            e_gv[f] = 1'b1;
                            e_gr[f*RW +: RW] = 3'(r);
                            e_fr[r] = 1'b1;
                        end
                    end
                end
            end
            inlist = 1'b0;
            foreach (order[k]) if (order[k] == int'(alloc_row)) inlist = 1'b1;
            e_err = alloc_valid && inlist;
            foreach (order[k]) if (!e_fr[order[k]]) keep.push_back(order[k]);
            order = keep;
            if (alloc_valid && !inlist) begin
                order.push_back(int'(alloc_row));
                mfu[alloc_row] = int'(alloc_fu);
            end
            e_cnt = 4'(order.size());
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);

        //  r  fl av ar af req    rdy  gv   gr      fr     cnt err
        add(1, 0, 0, 0, 0, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 0, 0);   // reset
        add(0, 0, 1, 3, 0, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 1, 0);   // rows 3,1,6 -> FU0
        add(0, 0, 1, 1, 0, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 2, 0);
        add(0, 0, 1, 6, 0, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 3, 0);
        add(0, 0, 0, 0, 0, 8'h4A, 4'hF, 4'h1, 12'h003, 8'h08, 2, 0);
        add(0, 0, 0, 0, 0, 8'h4A, 4'hF, 4'h1, 12'h001, 8'h02, 1, 0);
        add(0, 0, 0, 0, 0, 8'h4A, 4'hF, 4'h1, 12'h006, 8'h40, 0, 0);
        add(0, 0, 0, 0, 0, 8'h4A, 4'hF, 4'h0, 12'h000, 8'h00, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 1, 0);   // rows 0..3 -> FU0..3
        add(0, 0, 1, 1, 1, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 2, 0);
        add(0, 0, 1, 2, 2, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 3, 0);
        add(0, 0, 1, 3, 3, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 4, 0);
        add(0, 0, 0, 0, 0, 8'h0F, 4'hF, 4'hF, 12'h688, 8'h0F, 0, 0);
        add(0, 0, 1, 2, 1, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 1, 0);   // FU1 stalled
        add(0, 0, 0, 0, 0, 8'h04, 4'hD, 4'h0, 12'h000, 8'h00, 1, 0);
        add(0, 0, 0, 0, 0, 8'h04, 4'hD, 4'h0, 12'h000, 8'h00, 1, 0);
        add(0, 0, 0, 0, 0, 8'h04, 4'hD, 4'h0, 12'h000, 8'h00, 1, 0);
        add(0, 0, 0, 0, 0, 8'h04, 4'hF, 4'h2, 12'h010, 8'h04, 0, 0);
        for (int i = 0; i < NR; i++)                                     // fill window
            add(0, 0, 1, i, i % NF, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, i + 1, 0);
        add(0, 0, 1, 5, 3, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 8, 1);   // alloc when full
        add(0, 0, 0, 0, 0, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 8, 0);
        add(0, 0, 0, 0, 0, 8'h20, 4'hF, 4'h2, 12'h028, 8'h20, 7, 0);   // row 5 still FU1
        add(0, 1, 1, 5, 0, 8'hFF, 4'hF, 4'h0, 12'h000, 8'h00, 0, 0);   // flush wins
        add(0, 0, 0, 0, 0, 8'hFF, 4'hF, 4'h0, 12'h000, 8'h00, 0, 0);
        add(0, 0, 1, 4, 0, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 1, 0);
        add(0, 0, 1, 5, 1, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 2, 0);
        add(0, 0, 1, 6, 2, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 3, 0);
        add(0, 0, 1, 7, 3, 8'h00, 4'hF, 4'h0, 12'h000, 8'h00, 4, 0);
        add(1, 1, 1, 0, 0, 8'hF0, 4'hF, 4'h0, 12'h000, 8'h00, 0, 0);   // reset mid-operation
        add(0, 0, 0, 0, 0, 8'hF0, 4'hF, 4'h0, 12'h000, 8'h00, 0, 0);

        foreach (tbl[n]) begin
            drive(tbl[n].r, tbl[n].fl, tbl[n].av, tbl[n].ar, tbl[n].af, tbl[n].req, tbl[n].rdy);
            step();
            check_all($sformatf("vec%0d", n), tbl[n].gv, tbl[n].gr, tbl[n].fr, tbl[n].cnt,
                      tbl[n].err);
        end

        // Alloc into a row granted at the same edge errors; the row is not granted twice.
        drive(1'b0, 1'b0, 1'b1, 3'd2, 2'd0, 8'h00, 4'hF);
        step();
        check_all("same_edge/alloc", 4'h0, 12'h000, 8'h00, 4'd1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3'd2, 2'd1, 8'h04, 4'hF);
        step();
        check_all("same_edge/grant", 4'h1, 12'h002, 8'h04, 4'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h04, 4'hF);
        step();
        check_all("same_edge/no_regrant", 4'h0, 12'h000, 8'h00, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3'd2, 2'd1, 8'h00, 4'hF);
        step();
        check_all("same_edge/realloc", 4'h0, 12'h000, 8'h00, 4'd1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h04, 4'h2);
        step();
        check_all("same_edge/regrant", 4'h2, 12'h010, 8'h04, 4'd0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            drive(c == 0 || $urandom_range(0, 299) == 0,
                  $urandom_range(0, 79) == 0,
                  $urandom_range(0, 2) != 0,
                  3'($urandom_range(0, NR - 1)),
                  2'($urandom_range(0, NF - 1)),
                  8'($urandom | $urandom),
                  4'($urandom));
            model_edge();
            step();
            check_all($sformatf("rand%0d", c), e_gv, e_gr, e_fr, e_cnt, e_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
